bitty_fetch_unit: RTL and testbench
===================================

// Module: bitty_fetch_unit
// PURPOSE
//   Instruction fetch/sequencer directly upstream of bitty_core. Reads 16-bit instructions from a
//   synchronous instruction ROM/RAM and presents each one on the core's instruction/run inputs.
//   Waits for the core's done, then advances the PC. Stops after the instruction at stop_addr
//   completes, or on a watchdog timeout if done never arrives.
// PARAMETERS
//   ADDR_W      8    PC / memory address width; PC wraps modulo 2**ADDR_W
//   TIMEOUT_W   8    watchdog counter width; timeout after 2**TIMEOUT_W-1 cycles in EXEC
// PORTS
//   clk              in   1       single clock, rising edge
//   reset            in   1       synchronous, active-high
//   start            in   1       one-cycle request to start from start_addr (honoured in IDLE/HALT only)
//   start_addr       in   ADDR_W  first instruction address, sampled with start
//   stop_addr        in   ADDR_W  last instruction address, sampled with start
//   mem_rd_en        out  1       memory read strobe; data is valid exactly 1 cycle later
//   mem_addr         out  ADDR_W  memory read address (= pc)
//   mem_rdata        in   16      instruction word returned by the memory
//   core_run         out  1       to bitty_core.run; one-cycle pulse per instruction
//   core_instruction out  16      to bitty_core.instruction; held stable from ISSUE until done is seen
//   core_done        in   1       from bitty_core.done
//   pc               out  ADDR_W  address of the instruction currently in flight
//   busy             out  1       high in every state except IDLE and HALT
//   halted           out  1       high in HALT (program finished or timed out)
//   timeout          out  1       sticky; set on watchdog expiry, cleared by start or reset
// BEHAVIOUR
//   - Reset: state=IDLE. All outputs 0; pc=0, core_instruction=16'h0000.
//   - FSM: IDLE -start-> FETCH -> WAIT_MEM -> ISSUE -> EXEC -core_done-> (last ? HALT : FETCH).
//   - FETCH: mem_rd_en=1, mem_addr=pc for exactly 1 cycle.
//   - WAIT_MEM: capture mem_rdata into core_instruction at the end of the cycle.
//   - ISSUE: core_run=1 for exactly 1 cycle; clear the watchdog.
//   - EXEC: core_run=0; watchdog increments each cycle.
//   - Exit from EXEC on core_done==1:
//     - pc==stop_addr: go to HALT; pc holds.
//     - otherwise: pc<=pc+1 (wrap 2**ADDR_W-1 -> 0), go to FETCH.
//   - Issue-to-issue minimum is 4 cycles: done cycle + FETCH + WAIT_MEM + ISSUE.
//   - core_done is sampled only in EXEC. A done in FETCH/WAIT_MEM/ISSUE/IDLE/HALT is ignored.
//   - Watchdog: if the counter reaches all-ones in EXEC without done, set timeout=1, go to HALT.
//     - If done and expiry coincide, done wins.
//   - start in IDLE or HALT:
//     - pc<=start_addr; latch stop_addr; clear timeout and halted; go to FETCH.
//   - start while busy is ignored; latched stop_addr is unchanged.
//   - start_addr==stop_addr: exactly one instruction executes.
//   - stop_addr below start_addr: pc wraps through 2**ADDR_W-1 -> 0 and stops at stop_addr.
//   - reset in any state (including mid-EXEC): IDLE next cycle, all outputs at reset values.
//     The core is reset by the same signal.
//   - No combinational path from any input to any output; all outputs are registered.
// STRUCTURE
//   - Package bitty_fetch_pkg:
//     - state enum localparams: IDLE=0, FETCH=1, WAIT_MEM=2, ISSUE=3, EXEC=4, HALT=5 (3-bit).
//     - INSTR_W=16.
//   - One natural sub-module, bitty_watchdog: counter with clear/enable, expired flag.
//   - PC, stop-address latch and FSM stay in this module.
// TESTING
//   - Linear program:
//     - Stimulus: start_addr=0, stop_addr=3, ROM holds A0..A3, core stub returns done 2 cycles
//       after run.
//     - Expected: 4 run pulses carrying A0..A3 in order; halted=1 with pc=3.
//   - Wrap-around:
//     - Stimulus: ADDR_W=8, start_addr=8'hFE, stop_addr=8'h01.
//     - Expected: fetch order FE, FF, 00, 01; then HALT.
//   - Spurious done:
//     - Stimulus: core_done asserted during FETCH and ISSUE.
//     - Expected: ignored; pc does not advance until done is seen in EXEC.
//   - Timeout:
//     - Stimulus: core stub never asserts done.
//     - Expected: after 255 EXEC cycles (TIMEOUT_W=8), timeout=1, halted=1, busy=0.
//   - Start while busy:
//     - Stimulus: start pulse mid-program with a different stop_addr.
//     - Expected: ignored; original program completes at the original stop_addr.
//   - Reset mid-EXEC:
//     - Stimulus: assert reset 1 cycle while in EXEC.
//     - Expected: next cycle IDLE, pc=0, core_run=0, core_instruction=0. A new start runs cleanly.

Source files
------------

// File: rtl/bitty_fetch_pkg.sv
// Shared types for the bitty instruction fetch unit.
// FSM encoding and instruction width.
package bitty_fetch_pkg;

  localparam int INSTR_W = 16;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    WAIT_MEM = 3'd2,
    ISSUE    = 3'd3,
    EXEC     = 3'd4,
    HALT     = 3'd5
  } state_t;

endpackage

// File: rtl/bitty_watchdog.sv
// Saturating watchdog counter for the EXEC phase.
// expired flags the cycle whose increment reaches all-ones.
module bitty_watchdog #(
  parameter int W = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [W-1:0] ONES = '1;
  localparam logic [W-1:0] LAST = {{(W-1){1'b1}}, 1'b0};

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clr)
      cnt <= '0;
    else if (en && cnt != ONES)
      cnt <= cnt + 1'b1;
  end

  assign expired = en && (cnt == LAST);

endmodule

// File: rtl/bitty_fetch_unit.sv
// Fetch/sequencer feeding bitty_core: fetch, wait, issue, execute.
// All outputs are flops loaded from the next-state decode.
module bitty_fetch_unit
  import bitty_fetch_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int TIMEOUT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_W-1:0]  start_addr,
  input  logic [ADDR_W-1:0]  stop_addr,
  output logic               mem_rd_en,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic               core_run,
  output logic [INSTR_W-1:0] core_instruction,
  input  logic               core_done,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy,
  output logic               halted,
  output logic               timeout
);

  state_t            state;
  state_t            state_n;
  logic [ADDR_W-1:0] stop_q;
  logic              wd_expired;
  logic              take_start;
  logic              at_stop;

  assign take_start = start && (state == IDLE || state == HALT);
  assign at_stop    = (pc == stop_q);
  assign mem_addr   = pc;

  bitty_watchdog #(
    .W (TIMEOUT_W)
  ) u_wd (
    .clk     (clk),
    .reset   (reset),
    .clr     (state == ISSUE),
    .en      (state == EXEC),
    .expired (wd_expired)
  );

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE,
      HALT: if (take_start) state_n = FETCH;
      FETCH:    state_n = WAIT_MEM;
      WAIT_MEM: state_n = ISSUE;
      ISSUE:    state_n = EXEC;
      EXEC: begin
        if (core_done)
          state_n = at_stop ? HALT : FETCH;
        else if (wd_expired)
          state_n = HALT;
      end
      default:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc               <= '0;
      stop_q           <= '0;
      core_instruction <= '0;
      timeout          <= 1'b0;
      mem_rd_en        <= 1'b0;
      core_run         <= 1'b0;
      busy             <= 1'b0;
      halted           <= 1'b0;
    end else begin
      mem_rd_en <= (state_n == FETCH);
      core_run  <= (state_n == ISSUE);
      busy      <= !(state_n == IDLE || state_n == HALT);
      halted    <= (state_n == HALT);
      if (take_start) begin
        pc      <= start_addr;
        stop_q  <= stop_addr;
        timeout <= 1'b0;
      end
      if (state == WAIT_MEM)
        core_instruction <= mem_rdata;
      if (state == EXEC && core_done && !at_stop)
        pc <= pc + 1'b1;
      // done takes priority over a coinciding expiry
      if (state == EXEC && !core_done && wd_expired)
        timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bitty_fetch_unit.sv
// Directed bench for bitty_fetch_unit with ROM and core stubs.
module tb_bitty_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  start_addr;
  logic [7:0]  stop_addr;
  logic        mem_rd_en;
  logic [7:0]  mem_addr;
  logic [15:0] mem_rdata;
  logic        core_run;
  logic [15:0] core_instruction;
  logic        core_done;
  logic [7:0]  pc;
  logic        busy;
  logic        halted;
  logic        timeout;

  int total = 0;
  int bad   = 0;

  int   stub_mode;
  logic man_done;
  logic d1, d2;

  logic [15:0] run_q[$];
  logic [7:0]  fetch_q[$];

  always #5 clk = ~clk;

  bitty_fetch_unit #(
    .ADDR_W    (8),
    .TIMEOUT_W (8)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .start_addr       (start_addr),
    .stop_addr        (stop_addr),
    .mem_rd_en        (mem_rd_en),
    .mem_addr         (mem_addr),
    .mem_rdata        (mem_rdata),
    .core_run         (core_run),
    .core_instruction (core_instruction),
    .core_done        (core_done),
    .pc               (pc),
    .busy             (busy),
    .halted           (halted),
    .timeout          (timeout)
  );

  function automatic logic [15:0] rom(input logic [7:0] a);
    return 16'hA000 | {8'h00, a};
  endfunction

  always @(posedge clk)
    if (mem_rd_en) mem_rdata <= rom(mem_addr);

  always @(posedge clk) begin
    if (reset) begin
      d1 <= 1'b0;
      d2 <= 1'b0;
    end else begin
      d1 <= core_run;
      d2 <= d1;
    end
  end

  assign core_done = (stub_mode == 0) ? d2 :
                     (stub_mode == 2) ? man_done : 1'b0;

  always @(negedge clk) begin
    if (core_run) run_q.push_back(core_instruction);
    if (mem_rd_en) fetch_q.push_back(mem_addr);
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [7:0] sa, input logic [7:0] so);
    @(negedge clk);
    start      = 1'b1;
    start_addr = sa;
    stop_addr  = so;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_halt(input string tag, input int max);
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (halted) break;
    end
    chk(tag, {31'd0, halted}, 32'd1);
  endtask

  task automatic wait_run(input string tag, input int max);
    for (int i = 0; i < max; i++) begin
      if (core_run) break;
      @(negedge clk);
    end
    chk(tag, {31'd0, core_run}, 32'd1);
  endtask

  initial begin
    int n;
    reset      = 1'b1;
    start      = 1'b0;
    start_addr = '0;
    stop_addr  = '0;
    stub_mode  = 0;
    man_done   = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // reset state
    chk("rst_pc",    pc, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_halt",  halted, 0);
    chk("rst_tmo",   timeout, 0);
    chk("rst_run",   core_run, 0);
    chk("rst_rd",    mem_rd_en, 0);
    chk("rst_instr", core_instruction, 0);

    // linear program 0..3
    run_q.delete();
    do_start(8'h00, 8'h03);
    chk("lin_busy", busy, 1);
    wait_halt("lin_halt", 100);
    chk("lin_cnt", run_q.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("lin_instr", run_q[i], rom(8'(i)));
    chk("lin_pc", pc, 8'h03);
    chk("lin_busy_end", busy, 0);
    chk("lin_tmo", timeout, 0);

    // wrap FE..01
    fetch_q.delete();
    do_start(8'hFE, 8'h01);
    wait_halt("wrap_halt", 100);
    chk("wrap_cnt", fetch_q.size(), 4);
    chk("wrap_f0", fetch_q[0], 8'hFE);
    chk("wrap_f1", fetch_q[1], 8'hFF);
    chk("wrap_f2", fetch_q[2], 8'h00);
    chk("wrap_f3", fetch_q[3], 8'h01);
    chk("wrap_pc", pc, 8'h01);

    // spurious done in FETCH and ISSUE
    stub_mode = 2;
    do_start(8'h10, 8'h11);
    chk("sp_fetch", mem_rd_en, 1);
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    @(negedge clk);
    chk("sp_issue", core_run, 1);
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("sp_pc_hold", pc, 8'h10);
    chk("sp_exec_rd", mem_rd_en, 0);
    chk("sp_exec_busy", busy, 1);
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    chk("sp_pc_adv", pc, 8'h11);
    chk("sp_refetch", mem_rd_en, 1);
    stub_mode = 0;
    wait_halt("sp_halt", 100);
    chk("sp_pc_end", pc, 8'h11);

    // watchdog timeout
    stub_mode = 1;
    do_start(8'h20, 8'h25);
    wait_run("to_run", 20);
    n = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    chk("to_cycles", n, 255);
    chk("to_flag", timeout, 1);
    chk("to_halt", halted, 1);
    chk("to_busy", busy, 0);
    chk("to_pc", pc, 8'h20);

    // restart clears timeout; single instruction
    stub_mode = 0;
    run_q.delete();
    do_start(8'h30, 8'h30);
    chk("rs_tmo_clr", timeout, 0);
    chk("rs_halt_clr", halted, 0);
    wait_halt("rs_halt", 100);
    chk("rs_cnt", run_q.size(), 1);
    chk("rs_instr", run_q[0], 16'hA030);

    // start while busy ignored
    run_q.delete();
    fetch_q.delete();
    do_start(8'h40, 8'h43);
    repeat (5) @(negedge clk);
    do_start(8'h50, 8'h41);
    wait_halt("sb_halt", 100);
    chk("sb_cnt", run_q.size(), 4);
    chk("sb_last", run_q[3], 16'hA043);
    chk("sb_f0", fetch_q[0], 8'h40);
    chk("sb_pc", pc, 8'h43);

    // reset mid-EXEC
    do_start(8'h60, 8'h62);
    wait_run("rx_run", 20);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rx_pc", pc, 0);
    chk("rx_run0", core_run, 0);
    chk("rx_instr", core_instruction, 0);
    chk("rx_busy", busy, 0);
    chk("rx_halt", halted, 0);
    chk("rx_rd", mem_rd_en, 0);
    run_q.delete();
    do_start(8'h05, 8'h06);
    wait_halt("rx_new_halt", 100);
    chk("rx_new_cnt", run_q.size(), 2);
    chk("rx_new_i0", run_q[0], 16'hA005);
    chk("rx_new_i1", run_q[1], 16'hA006);
    chk("rx_new_pc", pc, 8'h06);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
